// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl
// Front-end redirect sequencer. When the EX-stage resolver reports a taken
// relative or absolute branch, the target is registered and offered to
// fetch. Once fetch accepts it, IF/ID are flushed for a fixed drain window.
//
// Handshake: redirect_valid is held with a stable redirect_pc until the cycle
// where redirect_valid & fetch_ready are both high; that cycle is the
// transfer. fetch_ready has no effect while redirect_valid is low.
//
// Optional build macro: BRANCH_REDIRECT_STATS_EN adds saturating counters
// for completed redirects and fetch back-pressure cycles.
module branch_redirect_ctrl #(
  parameter int XLEN         = 64,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic            pc_rel_branch,
  input  logic            pc_abs_branch,
  input  logic [XLEN-1:0] branch_base_pc,
  input  logic [XLEN-1:0] pc_imm_in,
  input  logic            fetch_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_front,
  output logic            ex_hold,
  output logic            busy,
  output logic [1:0]      state_dbg
`ifdef BRANCH_REDIRECT_STATS_EN
  ,
  output logic [31:0]     redirect_count,
  output logic [31:0]     redirect_stall_cycles
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;

  // Drain counter is loaded with DRAIN_CYCLES-1 so DRAIN lasts DRAIN_CYCLES cycles.
  localparam logic [3:0] DRAIN_INIT = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

  logic [1:0]      state;
  logic [3:0]      drain_cnt;
  logic            take;
  logic            in_idle;
  logic            handshake;
  logic [XLEN-1:0] target;

  // Branch detection and target selection; absolute redirect wins over relative.
  always_comb begin
    take      = ex_valid & (pc_rel_branch | pc_abs_branch);
    in_idle   = (state == ST_IDLE);
    handshake = (state == ST_REDIRECT) & fetch_ready;
    target    = pc_abs_branch ? pc_imm_in : (branch_base_pc + pc_imm_in);
  end

  // Output decode; flush in IDLE is combinational so wrong-path IF/ID die in the take cycle.
  always_comb begin
    redirect_valid = (state == ST_REDIRECT);
    ex_hold        = (state == ST_REDIRECT);
    busy           = !in_idle;
    flush_front    = in_idle ? take : 1'b1;
    state_dbg      = state;
  end

  // Redirect FSM, target register and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      redirect_pc <= '0;
      drain_cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            redirect_pc <= target;
            state       <= ST_REDIRECT;
          end
        end
        ST_REDIRECT: begin
          if (fetch_ready) begin
            if (DRAIN_CYCLES == 0) begin
              state <= ST_IDLE;
            end else begin
              drain_cnt <= DRAIN_INIT;
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef BRANCH_REDIRECT_STATS_EN
  // Saturating counters: accepted redirects and REDIRECT cycles stalled by fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_count        <= '0;
      redirect_stall_cycles <= '0;
    end else begin
      if (handshake && (redirect_count != 32'hFFFF_FFFF)) begin
        redirect_count <= redirect_count + 32'd1;
      end
      if ((state == ST_REDIRECT) && !fetch_ready &&
          (redirect_stall_cycles != 32'hFFFF_FFFF)) begin
        redirect_stall_cycles <= redirect_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl
// Directed bench for branch_redirect_ctrl (XLEN=64, DRAIN_CYCLES=2).
// Each take pushes its hand-computed target onto exp_q; a monitor pops and
// compares whenever the DUT completes a redirect handshake. Cycle-by-cycle
// control outputs are checked directly by the stimulus process.
// Honours BRANCH_REDIRECT_STATS_EN when the design is built with it.
module tb_branch_redirect_ctrl;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            ex_valid;
  logic            pc_rel_branch;
  logic            pc_abs_branch;
  logic [XLEN-1:0] branch_base_pc;
  logic [XLEN-1:0] pc_imm_in;
  logic            fetch_ready;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            flush_front;
  logic            ex_hold;
  logic            busy;
  logic [1:0]      state_dbg;
`ifdef BRANCH_REDIRECT_STATS_EN
  logic [31:0]     redirect_count;
  logic [31:0]     redirect_stall_cycles;
`endif

  logic [XLEN-1:0] exp_q[$];
  int total   = 0;
  int bad     = 0;
  int hs_seen = 0;

  branch_redirect_ctrl #(.XLEN(XLEN), .DRAIN_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .pc_rel_branch  (pc_rel_branch),
    .pc_abs_branch  (pc_abs_branch),
    .branch_base_pc (branch_base_pc),
    .pc_imm_in      (pc_imm_in),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush_front    (flush_front),
    .ex_hold        (ex_hold),
    .busy           (busy),
    .state_dbg      (state_dbg)
`ifdef BRANCH_REDIRECT_STATS_EN
    ,
    .redirect_count        (redirect_count),
    .redirect_stall_cycles (redirect_stall_cycles)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Scoreboard monitor: a handshake is visible mid-cycle before the capturing edge.
  always @(negedge clk) begin
    if (!rst && redirect_valid && fetch_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got redirect_pc=%h with no expected redirect", redirect_pc);
      end else begin
        logic [XLEN-1:0] e;
        e = exp_q.pop_front();
        hs_seen++;
        if (redirect_pc !== e) begin
          bad++;
          $display("FAIL sb_target: got %h want %h", redirect_pc, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic rv, input logic ff,
                           input logic eh, input logic bz);
    check({tag, "_redirect_valid"}, 64'(redirect_valid), 64'(rv));
    check({tag, "_flush_front"},    64'(flush_front),    64'(ff));
    check({tag, "_ex_hold"},        64'(ex_hold),        64'(eh));
    check({tag, "_busy"},           64'(busy),           64'(bz));
  endtask

  // Driver tasks
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ex_valid       = 1'b0;
    pc_rel_branch  = 1'b0;
    pc_abs_branch  = 1'b0;
    branch_base_pc = '0;
    pc_imm_in      = '0;
    fetch_ready    = 1'b0;
  endtask

  task automatic drive_take(input logic rel, input logic abs_b,
                            input logic [XLEN-1:0] base, input logic [XLEN-1:0] imm,
                            input logic [XLEN-1:0] exp_target);
    ex_valid       = 1'b1;
    pc_rel_branch  = rel;
    pc_abs_branch  = abs_b;
    branch_base_pc = base;
    pc_imm_in      = imm;
    exp_q.push_back(exp_target);
  endtask

  // Take at T, accept at T+1, drain T+2..T+3, idle at T+4.
  task automatic run_simple(input string tag, input logic rel, input logic abs_b,
                            input logic [XLEN-1:0] base, input logic [XLEN-1:0] imm,
                            input logic [XLEN-1:0] exp_target);
    drive_take(rel, abs_b, base, imm, exp_target);
    fetch_ready = 1'b1;
    @(negedge clk); check_ctl({tag, "_T0"}, 1'b0, 1'b1, 1'b0, 1'b0);
    next_cyc(); drive_idle(); fetch_ready = 1'b1;
    @(negedge clk); check_ctl({tag, "_T1"}, 1'b1, 1'b1, 1'b1, 1'b1);
    check({tag, "_pc_T1"}, redirect_pc, exp_target);
    next_cyc(); fetch_ready = 1'b0;
    @(negedge clk); check_ctl({tag, "_T2"}, 1'b0, 1'b1, 1'b0, 1'b1);
    next_cyc();
    @(negedge clk); check_ctl({tag, "_T3"}, 1'b0, 1'b1, 1'b0, 1'b1);
    next_cyc();
    @(negedge clk); check_ctl({tag, "_T4"}, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_pc_kept"}, redirect_pc, exp_target);
    next_cyc();
  endtask

  initial begin
    rst = 1'b1;
    drive_idle();
    #2;
    check_ctl("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_pc", redirect_pc, 64'h0);
    next_cyc();
    rst = 1'b0;
    next_cyc();

    // Absolute target with three back-pressure cycles.
    drive_take(1'b0, 1'b1, 64'h0, 64'h8000_0124, 64'h8000_0124);
    @(negedge clk); check_ctl("abs_T0", 1'b0, 1'b1, 1'b0, 1'b0);
    next_cyc(); drive_idle();
    for (int i = 1; i <= 4; i++) begin
      fetch_ready = (i == 4);
      @(negedge clk);
      check_ctl($sformatf("abs_T%0d", i), 1'b1, 1'b1, 1'b1, 1'b1);
      check($sformatf("abs_pc_T%0d", i), redirect_pc, 64'h8000_0124);
      next_cyc();
    end
    fetch_ready = 1'b0;
    @(negedge clk); check_ctl("abs_T5", 1'b0, 1'b1, 1'b0, 1'b1);
    next_cyc();
    @(negedge clk); check_ctl("abs_T6", 1'b0, 1'b1, 1'b0, 1'b1);
    next_cyc();
    @(negedge clk); check_ctl("abs_T7", 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef BRANCH_REDIRECT_STATS_EN
    check("abs_stall_cycles", 64'(redirect_stall_cycles), 64'd3);
    check("abs_count", 64'(redirect_count), 64'd1);
`endif
    next_cyc();

    // Relative branch, both-flag priority, and address wrap.
    run_simple("rel", 1'b1, 1'b0, 64'h8000_0000, 64'h10, 64'h8000_0010);
    run_simple("both", 1'b1, 1'b1, 64'h1000, 64'h2000, 64'h2000);
    run_simple("wrap", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h10, 64'h8);

    // Wrong-path takes during REDIRECT and DRAIN must be ignored.
    drive_take(1'b1, 1'b0, 64'h100, 64'h20, 64'h120);
    @(negedge clk); check_ctl("wp_T0", 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      next_cyc();
      ex_valid = 1'b1; pc_abs_branch = 1'b1; pc_rel_branch = 1'b1;
      branch_base_pc = 64'h5000; pc_imm_in = 64'hDEAD_0000 + 64'(i);
      fetch_ready = (i == 2);
      @(negedge clk);
      if (i <= 2) check_ctl($sformatf("wp_T%0d", i), 1'b1, 1'b1, 1'b1, 1'b1);
      else        check_ctl($sformatf("wp_T%0d", i), 1'b0, 1'b1, 1'b0, 1'b1);
      check($sformatf("wp_pc_T%0d", i), redirect_pc, 64'h120);
    end
    next_cyc(); drive_idle();
    @(negedge clk); check_ctl("wp_T5", 1'b0, 1'b0, 1'b0, 1'b0);
    check("wp_pc_T5", redirect_pc, 64'h120);
    next_cyc();

    // Asynchronous reset in the middle of REDIRECT discards the redirect.
    drive_take(1'b1, 1'b0, 64'h4000, 64'h40, 64'h4040);
    next_cyc(); drive_idle();
    #1 rst = 1'b1;
    #1;
    check_ctl("arst", 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst_pc", redirect_pc, 64'h0);
    void'(exp_q.pop_back());
    #1 rst = 1'b0;
    @(negedge clk); check_ctl("arst_after", 1'b0, 1'b0, 1'b0, 1'b0);
    next_cyc();
    run_simple("fresh", 1'b0, 1'b1, 64'h0, 64'h9000, 64'h9000);

    repeat (3) next_cyc();
    check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
    check("sb_handshakes", 64'(hs_seen), 64'd6);
`ifdef BRANCH_REDIRECT_STATS_EN
    check("end_count", 64'(redirect_count), 64'd1);
    check("end_stall_cycles", 64'(redirect_stall_cycles), 64'd0);
`endif

    // Final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
